// File: rtl/rng_byte_packer.sv
// Entropy byte packer: samples raw_bit, packs bits into bytes, queues them in a
// FIFO and launches each byte to a UART. Define RNG_VN_DEBIAS_EN for von Neumann debiasing.
module rng_byte_packer #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        raw_bit,
    input  logic                        tx_busy,
    output logic [7:0]                  tx_data,
    output logic                        tx_start,
    output logic [31:0]                 disp_word,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]    SAMP_LAST  = 8'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;

    tx_state_t     state;
    logic [1:0]    idle_cnt;
    logic [7:0]    samp_cnt;
    logic          strobe;
    logic          bit_valid;
    logic          bit_val;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [7:0]    push_byte;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign strobe = (samp_cnt == SAMP_LAST);

    always_ff @(posedge clk) begin
        if (reset || strobe) samp_cnt <= '0;
        else                 samp_cnt <= samp_cnt + 8'd1;
    end

`ifdef RNG_VN_DEBIAS_EN
    logic pair_second;
    logic pair_first;

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_second <= 1'b0;
            pair_first  <= 1'b0;
        end else if (strobe) begin
            pair_second <= ~pair_second;
            if (!pair_second) pair_first <= raw_bit;
        end
    end

    // (0,1) -> 0 and (1,0) -> 1, so the emitted bit is simply the first sample
    always_comb begin
        bit_valid = strobe && pair_second && (pair_first != raw_bit);
        bit_val   = pair_first;
    end
`else
    always_comb begin
        bit_valid = strobe;
        bit_val   = raw_bit;
    end
`endif

    assign push_byte = {shreg[6:0], bit_val};
    assign push      = bit_valid && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (bit_valid) begin
            shreg   <= push_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign full  = (fifo_count == FULL_COUNT);
    assign pop   = (state == IDLE) && (fifo_count != '0) && !tx_busy;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (push && full && !pop) overflow <= 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idle_cnt  <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            disp_word <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data   <= mem[rd_ptr];
                        disp_word <= {disp_word[23:0], mem[rd_ptr]};
                        tx_start  <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    idle_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // give up after 4 idle cycles so a silent UART cannot stall the queue
                    if (tx_busy)                state    <= WAIT_DONE;
                    else if (idle_cnt == 2'd3)  state    <= IDLE;
                    else                        idle_cnt <= idle_cnt + 2'd1;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_byte_packer.sv
// Directed self-checking bench for rng_byte_packer (SAMPLE_DIV=1 main instance,
// default-parameter instance for the sample divider).
module tb_rng_byte_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        raw_bit = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [31:0] disp_word;
    logic [4:0]  fifo_count;
    logic        overflow;

    logic        raw_bit4 = 1'b0;
    logic        tx_busy4 = 1'b0;
    logic [7:0]  tx_data4;
    logic        tx_start4;
    logic [31:0] disp_word4;
    logic [4:0]  fifo_count4;
    logic        overflow4;

    int n_checks = 0;
    int n_fail = 0;

    bit uart_en = 1'b0;
    bit start_prev = 1'b0;
    int busy_left = 0;

    always #5 clk = ~clk;

    rng_byte_packer #(.SAMPLE_DIV(1), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .raw_bit(raw_bit), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start), .disp_word(disp_word),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    rng_byte_packer #(.SAMPLE_DIV(4), .FIFO_DEPTH(16)) dut4 (
        .clk(clk), .reset(reset), .raw_bit(raw_bit4), .tx_busy(tx_busy4),
        .tx_data(tx_data4), .tx_start(tx_start4), .disp_word(disp_word4),
        .fifo_count(fifo_count4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the UART model raises busy one cycle after tx_start, for 10 cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (uart_en) begin
            if (busy_left > 0) busy_left--;
            if (start_prev) busy_left = 10;
            tx_busy = (busy_left > 0);
            start_prev = tx_start;
        end
    endtask

    task automatic do_reset();
        uart_en = 1'b0;
        busy_left = 0;
        start_prev = 1'b0;
        tx_busy = 1'b0;
        raw_bit = 1'b0;
        raw_bit4 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) begin
            raw_bit = v[b];
            tick();
        end
    endtask

    task automatic wait_launch(input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (tx_start !== 1'b1 && waited < budget);
        if (tx_start !== 1'b1) check("launch_timeout", tx_start, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nl;
        int last_c;
        logic [7:0] prev_data;
        logic [7:0] last_byte;
        logic [7:0] exp_bytes [4];
        logic [31:0] pat;
        logic [7:0] v4;
        logic [19:0] pairs;

        // Reset values, with inputs toggled to non-idle levels
        reset = 1'b1;
        raw_bit = 1'b1;
        raw_bit4 = 1'b1;
        repeat (3) tick();
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_disp_word", disp_word, 32'h0);
        check("rst_fifo_count", fifo_count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_fifo_count4", fifo_count4, 5'd0);

`ifdef RNG_VN_DEBIAS_EN
        // Pairs 01,11,10,00,10,10,01,01,10,01 -> bits 0,1,1,1,0,0,1,0 -> 0x72
        do_reset();
        pairs = 20'b01_11_10_00_10_10_01_01_10_01;
        for (int c = 19; c >= 0; c--) begin
            raw_bit = pairs[c];
            tick();
            if (c == 1) check("vn_count_before", fifo_count, 5'd0);
        end
        check("vn_count_after", fifo_count, 5'd1);
        raw_bit = 1'b0;
        tick();
        check("vn_tx_start", tx_start, 1'b1);
        check("vn_tx_data", tx_data, 8'h72);
`else
        // Scenario 1: bits 1,0,1,1,0,0,1,0 -> 0xB2, launch two cycles after the 8th bit
        reset = 1'b0;
        pat = 32'hB2;
        for (int b = 7; b >= 0; b--) begin
            raw_bit = pat[b];
            tick();
            if (b == 1) check("s1_count_7bits", fifo_count, 5'd0);
        end
        check("s1_count_8bits", fifo_count, 5'd1);
        check("s1_no_early_start", tx_start, 1'b0);
        raw_bit = 1'b0;
        tick();
        check("s1_tx_start", tx_start, 1'b1);
        check("s1_tx_data", tx_data, 8'hB2);
        check("s1_disp_word", disp_word, 32'h0000_00B2);
        check("s1_count_popped", fifo_count, 5'd0);
        tick();
        check("s1_start_single", tx_start, 1'b0);
        check("s1_data_hold", tx_data, 8'hB2);

        // Sample divider 4: only every 4th cycle is captured; other cycles carry inverted bits
        do_reset();
        v4 = 8'h96;
        for (int c = 1; c <= 32; c++) begin
            raw_bit4 = (c % 4 == 0) ? v4[7 - (c - 1) / 4] : ~v4[7 - (c - 1) / 4];
            tick();
            if (c == 31) check("div4_count_31", fifo_count4, 5'd0);
        end
        check("div4_count_32", fifo_count4, 5'd1);
        raw_bit4 = 1'b0;
        tick();
        check("div4_tx_start", tx_start4, 1'b1);
        check("div4_tx_data", tx_data4, 8'h96);

        // Scenario 3: busy held, 17 bytes -> full + overflow; then push and pop while full
        do_reset();
        tx_busy = 1'b1;
        for (int i = 1; i <= 16; i++) feed_byte(8'(8'h40 + i));
        check("s3_full_count", fifo_count, 5'd16);
        check("s3_no_overflow_yet", overflow, 1'b0);
        feed_byte(8'h51);
        check("s3_drop_count", fifo_count, 5'd16);
        check("s3_overflow", overflow, 1'b1);
        pat = 32'h77;
        for (int b = 7; b >= 1; b--) begin
            raw_bit = pat[b];
            tick();
        end
        tx_busy = 1'b0;
        raw_bit = pat[0];
        tick();
        check("s3_pushpop_count", fifo_count, 5'd16);
        check("s3_launch1_start", tx_start, 1'b1);
        check("s3_launch1_data", tx_data, 8'h41);
        raw_bit = 1'b0;
        // Scenario 5 is exercised here: busy never rises, so launches recur every 6 cycles
        for (int j = 2; j <= 17; j++) begin
            wait_launch(20, w);
            if (j == 2) check("s5_timeout_spacing", w, 6);
            check($sformatf("s3_drain_%0d", j), tx_data, (j <= 16) ? 8'(8'h40 + j) : 8'h77);
        end
        check("s3_overflow_sticky", overflow, 1'b1);

        // Scenario 4: UART busy for 10 cycles after each launch
        do_reset();
        uart_en = 1'b1;
        pat = 32'h1122_3344;
        exp_bytes[0] = 8'h11;
        exp_bytes[1] = 8'h22;
        exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44;
        nl = 0;
        last_c = 0;
        last_byte = 8'h00;
        for (int c = 1; c <= 52; c++) begin
            raw_bit = (c <= 32) ? pat[32 - c] : 1'b0;
            prev_data = tx_data;
            tick();
            if (tx_start === 1'b1) begin
                if (nl > 0) begin
                    check("s4_spacing_ge12", (c - last_c) >= 12, 1'b1);
                    check("s4_data_held", prev_data, last_byte);
                end
                if (nl < 4) check($sformatf("s4_byte_%0d", nl), tx_data, exp_bytes[nl]);
                nl++;
                last_c = c;
                last_byte = tx_data;
            end
        end
        check("s4_launches", nl, 4);
        check("s4_disp_word", disp_word, 32'h1122_3344);

        // Scenario 6: reset mid-transfer and mid-byte with 3 bytes queued
        do_reset();
        feed_byte(8'hA1);
        pat = 32'hB2;
        raw_bit = pat[7];
        tick();
        check("s6_first_launch", tx_start, 1'b1);
        check("s6_first_data", tx_data, 8'hA1);
        tx_busy = 1'b1;
        for (int b = 6; b >= 0; b--) begin
            raw_bit = pat[b];
            tick();
        end
        feed_byte(8'hC3);
        feed_byte(8'hD4);
        raw_bit = 1'b1;
        repeat (5) tick();
        check("s6_queued", fifo_count, 5'd3);
        reset = 1'b1;
        tick();
        tick();
        check("s6_rst_tx_data", tx_data, 8'h00);
        check("s6_rst_tx_start", tx_start, 1'b0);
        check("s6_rst_disp_word", disp_word, 32'h0);
        check("s6_rst_fifo_count", fifo_count, 5'd0);
        check("s6_rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        feed_byte(8'h5A);
        check("s6_fresh_count", fifo_count, 5'd1);
        check("s6_busy_blocks", tx_start, 1'b0);
        tx_busy = 1'b0;
        raw_bit = 1'b0;
        tick();
        check("s6_relaunch", tx_start, 1'b1);
        check("s6_fresh_byte", tx_data, 8'h5A);
        check("s6_disp_word", disp_word, 32'h0000_005A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rng_byte_packer.md
RNG_BYTE_PACKER -- requirements
Module: rng_byte_packer

Interface
REQ-001 The parameter SAMPLE_DIV SHALL default to 4: raw_bit is sampled once every SAMPLE_DIV clk cycles; legal values are 1 to 255.
REQ-002 The parameter FIFO_DEPTH SHALL default to 16: byte FIFO depth; it must be a power of two, from 2 to 256.
REQ-003 The port clk SHALL be: input, 1 bit, the single system clock; all logic is on the rising edge.
REQ-004 The port reset SHALL be: input, 1 bit, synchronous and active-high.
REQ-005 The port raw_bit SHALL be: input, 1 bit, entropy bit already synchronised to clk (XOR of the ring oscillators).
REQ-006 The port tx_busy SHALL be: input, 1 bit, UART transmitter busy.
REQ-007 The port tx_data SHALL be: output, 8 bits, byte offered to the UART.
REQ-008 The port tx_start SHALL be: output, 1 bit, single-cycle pulse that launches the UART with tx_data.
REQ-009 The port disp_word SHALL be: output, 32 bits, the last four bytes launched, with the newest in [7:0].
REQ-010 The port fifo_count SHALL be: output, $clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.
REQ-011 The port overflow SHALL be: output, 1 bit, sticky flag meaning at least one byte was dropped.

Function
REQ-012 The sample counter SHALL count 0..SAMPLE_DIV-1 and wrap; a sample strobe fires in the cycle the count equals SAMPLE_DIV-1, and raw_bit is captured in that cycle.
REQ-013 Each accepted bit SHALL shift into an 8-bit register LSB-side (shreg <= {shreg[6:0], bit}), and a 3-bit counter SHALL track the bits accepted.
REQ-014 The 8th accepted bit SHALL complete a byte; the full byte, including that bit, is pushed into the FIFO on the next clk edge, and the bit counter wraps to 0.
REQ-015 On a push while the FIFO is full with no simultaneous pop, the byte SHALL be discarded, overflow set to 1 and held until reset, and the FIFO contents left unchanged.
REQ-016 On a push and a pop in the same cycle while the FIFO is full, both SHALL occur; there is no drop and fifo_count stays unchanged.
REQ-017 The transmit FSM SHALL have the states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-018 In IDLE with fifo_count != 0 and tx_busy == 0, the FSM SHALL pop the head byte into tx_data, go to START, and assert tx_start for exactly one cycle.
REQ-019 In START, the FSM SHALL go to WAIT_BUSY unconditionally.
REQ-020 In WAIT_BUSY, the FSM SHALL go to WAIT_DONE when tx_busy == 1; if tx_busy stays 0 for 4 consecutive cycles, it SHALL return to IDLE to prevent a lockup.
REQ-021 In WAIT_DONE, the FSM SHALL go to IDLE on the first cycle in which tx_busy == 0.
REQ-022 Latency SHALL be one cycle: tx_start asserts in the cycle after the FIFO becomes non-empty, provided the FSM is in IDLE and tx_busy == 0.
REQ-023 tx_data SHALL hold its value from tx_start until the next launch.
REQ-024 disp_word SHALL update to {disp_word[23:0], tx_data} in the cycle tx_start is high, using the byte being launched.
REQ-025 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-026 While reset is 1, tx_data, tx_start, disp_word, fifo_count and overflow SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-027 Reset SHALL clear the sample counter, shift register, bit counter, FIFO pointers and the debias pair state; a partially assembled byte is lost.
REQ-028 A reset asserted mid-transfer SHALL return the FSM to IDLE regardless of tx_busy; after release, the next launch still waits for tx_busy == 0.

Configuration
REQ-029 With the macro RNG_VN_DEBIAS_EN defined, samples SHALL be grouped into non-overlapping pairs (first, second): pair (0,1) emits bit 0, pair (1,0) emits bit 1, and pairs (0,0) and (1,1) emit nothing.
REQ-030 With RNG_VN_DEBIAS_EN defined, the pair phase SHALL reset to "expecting first".
REQ-031 Without RNG_VN_DEBIAS_EN, every sample strobe SHALL emit the captured raw_bit directly, and no pair logic is synthesised.

Verification
REQ-032 Scenario 1, no debias, SAMPLE_DIV=1, raw_bit sequence 1,0,1,1,0,0,1,0, tx_busy=0: the FIFO receives 0xB2, and tx_start pulses 2 cycles after the 8th bit with tx_data=0xB2.
REQ-033 Scenario 2, debias, SAMPLE_DIV=1, sample pairs 01,11,10,00,10,10,01,01,10,01: the emitted bits are 0,1,1,1,0,0,1,0 and the FIFO receives 0x72.
REQ-034 Scenario 3, tx_busy held at 1, 17 bytes generated with FIFO_DEPTH=16: fifo_count=16, overflow=1, and releasing busy drains exactly bytes 1..16 in order.
REQ-035 Scenario 4, UART model that raises busy 1 cycle after tx_start for 10 cycles, bytes 0x11, 0x22, 0x33 and 0x44 sent: disp_word=0x11223344, and tx_start pulses are spaced at least 12 cycles apart.
REQ-036 Scenario 5, tx_busy never rises after tx_start: the FSM returns to IDLE after 4 cycles in WAIT_BUSY, and the next byte launches.
REQ-037 Scenario 6, reset pulsed after 5 of 8 bits with 3 bytes queued: all outputs are 0 and fifo_count=0, and the next byte is built from 8 fresh bits.
